// File: rtl/oh_fifo_sync_if.sv
// oh_fifo_sync_if: bundle of FIFO control, data and status signals.
//   master : the user side. It drives clear, wr_en, din and rd_en, and it
//            observes dout, the flags and count.
//   slave  : the FIFO side, with the opposite directions.
//   DW     : data width.
//   AW     : pointer width. count is AW+1 bits wide.
interface oh_fifo_sync_if #(
  parameter int DW = 32,
  parameter int AW = 4
);
  logic          clear;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic          prog_full;
  logic          prog_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  modport master (
    output clear, wr_en, din, rd_en,
    input  dout, empty, full, prog_full, prog_empty, count, overflow, underflow
  );

  modport slave (
    input  clear, wr_en, din, rd_en,
    output dout, empty, full, prog_full, prog_empty, count, overflow, underflow
  );
endinterface

// File: rtl/oh_fifo_sync.sv
// oh_fifo_sync: single-clock FIFO with these features:
//   - true occupancy count
//   - programmable full and empty thresholds
//   - optional first-word-fall-through (FWFT)
//   - synchronous flush
//   - sticky overflow and underflow flags
// DEPTH can be any value of 2 or more.
// Ports:
//   clk    : clock. All logic is on the rising edge.
//   nreset : synchronous reset, active low. It has priority over everything.
//   fifo   : slave modport of oh_fifo_sync_if. It carries:
//            - clear, wr_en, din, rd_en
//            - dout, empty, full, prog_full, prog_empty, count
//            - overflow, underflow
module oh_fifo_sync #(
  parameter int DW         = 32,
  parameter int DEPTH      = 16,
  parameter int PROG_FULL  = DEPTH - 2,
  parameter int PROG_EMPTY = 2,
  parameter int FWFT       = 0,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           nreset,
  oh_fifo_sync_if.slave  fifo
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   PF_CNT   = (AW+1)'(PROG_FULL);
  localparam logic [AW:0]   PE_CNT   = (AW+1)'(PROG_EMPTY);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          ovf, unf;
  logic          full_w, empty_w, wr_ok, rd_ok;

  // DEPTH need not be a power of two, so the pointers wrap explicitly.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // All flags decode from the registered count.
  assign full_w  = (cnt == FULL_CNT);
  assign empty_w = (cnt == '0);
  // When full, a read still proceeds and the write is refused.
  // When empty, the reverse applies.
  assign wr_ok   = fifo.wr_en & ~full_w;
  assign rd_ok   = fifo.rd_en & ~empty_w;

  always_ff @(posedge clk) begin
    if (!nreset || fifo.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_ok && !rd_ok)      cnt <= cnt + 1'b1;
      else if (rd_ok && !wr_ok) cnt <= cnt - 1'b1;
      if (fifo.wr_en && full_w)  ovf <= 1'b1;
      if (fifo.rd_en && empty_w) unf <= 1'b1;
    end
  end

  // The storage has no reset. A write is gated off by reset and flush.
  always_ff @(posedge clk) begin
    if (nreset && !fifo.clear && wr_ok) mem[wr_ptr] <= fifo.din;
  end

  if (FWFT == 0) begin : g_reg
    // Registered read: dout updates only on an accepted read.
    // A flush leaves dout unchanged.
    logic [DW-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (!nreset)                   dout_q <= '0;
      else if (!fifo.clear && rd_ok) dout_q <= mem[rd_ptr];
    end
    assign fifo.dout = dout_q;
  end else begin : g_fwft
    // The head word is always presented. dout is meaningless while empty.
    assign fifo.dout = mem[rd_ptr];
  end

  assign fifo.empty      = empty_w;
  assign fifo.full       = full_w;
  assign fifo.prog_full  = (cnt >= PF_CNT);
  assign fifo.prog_empty = (cnt <= PE_CNT);
  assign fifo.count      = cnt;
  assign fifo.overflow   = ovf;
  assign fifo.underflow  = unf;

endmodule

// File: tb/tb_oh_fifo_sync.sv
module tb_oh_fifo_sync;
  localparam int DW = 8, DEPTH = 5, AW = 3, PF = 4, PE = 1;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic clear = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] din = '0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  oh_fifo_sync_if #(.DW(DW), .AW(AW)) if0 ();
  oh_fifo_sync_if #(.DW(DW), .AW(AW)) if1 ();

  assign if0.clear = clear;
  assign if0.wr_en = wr_en;
  assign if0.din   = din;
  assign if0.rd_en = rd_en;
  assign if1.clear = clear;
  assign if1.wr_en = wr_en;
  assign if1.din   = din;
  assign if1.rd_en = rd_en;

  oh_fifo_sync #(.DW(DW), .DEPTH(DEPTH), .PROG_FULL(PF), .PROG_EMPTY(PE), .FWFT(0))
    u_reg  (.clk(clk), .nreset(nreset), .fifo(if0));
  oh_fifo_sync #(.DW(DW), .DEPTH(DEPTH), .PROG_FULL(PF), .PROG_EMPTY(PE), .FWFT(1))
    u_fwft (.clk(clk), .nreset(nreset), .fifo(if1));

  // Reference model: a queue of words, the sticky flags, and the registered dout.
  logic [DW-1:0] q[$];
  logic m_ovf = 1'b0, m_unf = 1'b0;
  logic [DW-1:0] m_dout = '0;
  int max_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("count0",      32'(if0.count),      32'(n));
    chk("empty0",      32'(if0.empty),      32'(n == 0));
    chk("full0",       32'(if0.full),       32'(n == DEPTH));
    chk("prog_full0",  32'(if0.prog_full),  32'(n >= PF));
    chk("prog_empty0", 32'(if0.prog_empty), 32'(n <= PE));
    chk("overflow0",   32'(if0.overflow),   32'(m_ovf));
    chk("underflow0",  32'(if0.underflow),  32'(m_unf));
    chk("dout_reg",    32'(if0.dout),       32'(m_dout));
    chk("count1",      32'(if1.count),      32'(n));
    chk("empty1",      32'(if1.empty),      32'(n == 0));
    chk("overflow1",   32'(if1.overflow),   32'(m_ovf));
    chk("underflow1",  32'(if1.underflow),  32'(m_unf));
    if (n > 0) chk("dout_fwft", 32'(if1.dout), 32'(q[0]));
  endtask

  // Apply one cycle of inputs, advance the model by the FIFO rules, then compare.
  task automatic step(input logic nr, input logic w, input logic [DW-1:0] d,
                      input logic r, input logic c);
    logic wa, ra;
    nreset = nr; wr_en = w; din = d; rd_en = r; clear = c;
    @(posedge clk);
    if (!nr) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0;
    end else if (c) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      wa = w && (q.size() < DEPTH);
      ra = r && (q.size() > 0);
      if (w && q.size() == DEPTH) m_ovf = 1'b1;
      if (r && q.size() == 0)     m_unf = 1'b1;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
    end
    if (q.size() > max_cnt) max_cnt = q.size();
    #1;
    check_all();
  endtask

  initial begin
    // Reset is held while both write and read are requested.
    repeat (3) step(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    chk("rst_dout", 32'(if0.dout), 32'h0);

    // Fill to full, attempt one overflowing write, drain, then underflow.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    chk("filled_full", 32'(if0.full), 32'h1);
    step(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("ovf_set", 32'(if0.overflow), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_order", 32'(if0.dout), 32'(8'hA0 + i));
    end
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // Wrap: each read runs one word behind the write, so the pointers wrap
    // more than once.
    max_cnt = 0;
    step(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
    for (int i = 1; i <= 13; i++) step(1'b1, 1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_last", 32'(if0.dout), 32'h1D);
    chk("wrap_maxcnt", 32'(max_cnt <= 2), 32'h1);

    // Boundaries.
    // wr+rd while full: the read proceeds and the write is refused.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h3F, 1'b1, 1'b0);
    chk("full_wr_rd_cnt", 32'(if0.count), 32'd4);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    // wr+rd while empty: the write proceeds and the read is refused.
    step(1'b1, 1'b1, 8'h40, 1'b1, 1'b0);
    chk("empty_wr_rd_cnt", 32'(if0.count), 32'd1);
    chk("empty_wr_rd_unf", 32'(if0.underflow), 32'h1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    // wr+rd at count 3: count is unchanged and no flag is set.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h53, 1'b1, 1'b0);
    chk("mid_wr_rd_cnt", 32'(if0.count), 32'd3);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // Modes. With FWFT the word shows without a read.
    // With the registered read it shows only after a read.
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    chk("fwft_0x55", 32'(if1.dout), 32'h55);
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("reg_0x55", 32'(if0.dout), 32'h55);
    // A flush in mid-stream, with a write requested at the same edge.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    chk("clear_empty", 32'(if0.empty), 32'h1);

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), 8'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
